// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute,
// plus combinational ALU, branch and immediate-format decode.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_imm_src,
  output logic       o_reg_write,
  output logic [3:0] o_alu_control,
  output logic [3:0] o_state
);

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned STATE_W = 4;

  // Major opcodes
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1010;

  // ALU A-input selects
  localparam logic [SEL_W-1:0] A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] A_OLDPC  = 2'b01;
  localparam logic [SEL_W-1:0] A_RS1    = 2'b10;
  localparam logic [SEL_W-1:0] A_ZERO   = 2'b11;

  // ALU B-input selects
  localparam logic [SEL_W-1:0] B_RS2    = 2'b00;
  localparam logic [SEL_W-1:0] B_IMM    = 2'b01;
  localparam logic [SEL_W-1:0] B_FOUR   = 2'b10;

  // Result mux selects
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  // Immediate formats
  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [ALU_W-1:0]   w_arith_op;
  logic [ALU_W-1:0]   w_br_op;
  logic               w_br_take;
  logic [IMM_W-1:0]   w_imm_src;

  logic               w_pc_write;
  logic               w_adr_src;
  logic               w_mem_write;
  logic               w_ir_write;
  logic [SEL_W-1:0]   w_result_src;
  logic [SEL_W-1:0]   w_alu_src_a;
  logic [SEL_W-1:0]   w_alu_src_b;
  logic               w_reg_write;
  logic [ALU_W-1:0]   w_alu_control;

  // State register; reset wins even mid-instruction
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // funct3 ALU decode for R-type and I-type arithmetic; SUB only exists for R-type
  always_comb begin
    w_arith_op = ALU_ADD;
    case (i_funct3)
      3'b000:  w_arith_op = ((i_opcode == OP_R) && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_arith_op = ALU_SLL;
      3'b010:  w_arith_op = ALU_SLT;
      3'b011:  w_arith_op = ALU_SLTU;
      3'b100:  w_arith_op = ALU_XOR;
      3'b101:  w_arith_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_arith_op = ALU_OR;
      default: w_arith_op = ALU_AND;
    endcase
  end

  // Branch compare op and take condition; SLT/SLTU result is 1 when rs1 < rs2
  always_comb begin
    w_br_op   = ALU_AND;
    w_br_take = 1'b0;
    case (i_funct3)
      3'b000:  begin w_br_op = ALU_SUB;  w_br_take = i_zero;  end
      3'b001:  begin w_br_op = ALU_SUB;  w_br_take = !i_zero; end
      3'b100:  begin w_br_op = ALU_SLT;  w_br_take = !i_zero; end
      3'b101:  begin w_br_op = ALU_SLT;  w_br_take = i_zero;  end
      3'b110:  begin w_br_op = ALU_SLTU; w_br_take = !i_zero; end
      3'b111:  begin w_br_op = ALU_SLTU; w_br_take = i_zero;  end
      default: begin w_br_op = ALU_AND;  w_br_take = 1'b0;    end
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    w_imm_src = IMM_I;
    case (i_opcode)
      OP_STORE:         w_imm_src = IMM_S;
      OP_BRANCH:        w_imm_src = IMM_B;
      OP_JAL:           w_imm_src = IMM_J;
      OP_LUI, OP_AUIPC: w_imm_src = IMM_U;
      default:          w_imm_src = IMM_I;
    endcase
  end

  // Next-state and Moore control outputs per state
  always_comb begin
    w_next_state  = S_FETCH;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_result_src  = RES_ALUOUT;
    w_alu_src_a   = A_PC;
    w_alu_src_b   = B_RS2;
    w_reg_write   = 1'b0;
    w_alu_control = ALU_AND;

    case (r_state)
      S_FETCH: begin
        w_ir_write    = 1'b1;
        w_alu_src_a   = A_PC;
        w_alu_src_b   = B_FOUR;
        w_alu_control = ALU_ADD;
        w_result_src  = RES_ALU;
        w_pc_write    = 1'b1;
        w_next_state  = S_DECODE;
      end
      S_DECODE: begin
        // old_pc + imm is precomputed for branches and JAL
        w_alu_src_a   = A_OLDPC;
        w_alu_src_b   = B_IMM;
        w_alu_control = ALU_ADD;
        case (i_opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_R:              w_next_state = S_EXECR;
          OP_I:              w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
          OP_AUIPC:          w_next_state = S_AUIPC;
          default:           w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a   = A_RS1;
        w_alu_src_b   = B_IMM;
        w_alu_control = ALU_ADD;
        w_next_state  = (i_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_result_src = RES_ALUOUT;
        w_adr_src    = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_result_src = RES_ALUOUT;
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a   = A_RS1;
        w_alu_src_b   = B_RS2;
        w_alu_control = w_arith_op;
        w_next_state  = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a   = A_RS1;
        w_alu_src_b   = B_IMM;
        w_alu_control = w_arith_op;
        w_next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        w_result_src = RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        // alu_out holds the target from DECODE; load it into PC if taken
        w_alu_src_a   = A_RS1;
        w_alu_src_b   = B_RS2;
        w_result_src  = RES_ALUOUT;
        w_alu_control = w_br_op;
        w_pc_write    = w_br_take;
        w_next_state  = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target in alu_out while the ALU forms old_pc + 4 for rd
        w_alu_src_a   = A_OLDPC;
        w_alu_src_b   = B_FOUR;
        w_alu_control = ALU_ADD;
        w_result_src  = RES_ALUOUT;
        w_pc_write    = 1'b1;
        w_next_state  = S_ALUWB;
      end
      S_JALR: begin
        // Overwrite alu_out with rs1 + imm, then share the JAL path
        w_alu_src_a   = A_RS1;
        w_alu_src_b   = B_IMM;
        w_alu_control = ALU_ADD;
        w_next_state  = S_JAL;
      end
      S_LUI: begin
        w_alu_src_a   = A_ZERO;
        w_alu_src_b   = B_IMM;
        w_alu_control = ALU_ADD;
        w_next_state  = S_ALUWB;
      end
      S_AUIPC: begin
        w_alu_src_a   = A_OLDPC;
        w_alu_src_b   = B_IMM;
        w_alu_control = ALU_ADD;
        w_next_state  = S_ALUWB;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, even before the state updates
  always_comb begin
    o_pc_write    = 1'b0;
    o_adr_src     = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_result_src  = RES_ALUOUT;
    o_alu_src_a   = A_PC;
    o_alu_src_b   = B_RS2;
    o_imm_src     = IMM_I;
    o_reg_write   = 1'b0;
    o_alu_control = ALU_AND;
    o_state       = STATE_W'(0);
    if (!i_reset) begin
      o_pc_write    = w_pc_write;
      o_adr_src     = w_adr_src;
      o_mem_write   = w_mem_write;
      o_ir_write    = w_ir_write;
      o_result_src  = w_result_src;
      o_alu_src_a   = w_alu_src_a;
      o_alu_src_b   = w_alu_src_b;
      o_imm_src     = w_imm_src;
      o_reg_write   = w_reg_write;
      o_alu_control = w_alu_control;
      o_state       = STATE_W'(r_state);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic       reg_write;
  logic [3:0] alu_control;
  logic [3:0] state;

  int n_cmp;
  int n_bad;

  multicycle_control dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_opcode      (opcode),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_zero        (zero),
    .o_pc_write    (pc_write),
    .o_adr_src     (adr_src),
    .o_mem_write   (mem_write),
    .o_ir_write    (ir_write),
    .o_result_src  (result_src),
    .o_alu_src_a   (alu_src_a),
    .o_alu_src_b   (alu_src_b),
    .o_imm_src     (imm_src),
    .o_reg_write   (reg_write),
    .o_alu_control (alu_control),
    .o_state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then sample away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    opcode   = 7'b0100011;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;

    // Reset held: everything quiet, imm_src gated despite store opcode
    step();
    step();
    chk("rst_state",    8'(state),       8'h0);
    chk("rst_pc_write", 8'(pc_write),    8'h0);
    chk("rst_ir_write", 8'(ir_write),    8'h0);
    chk("rst_alu_b",    8'(alu_src_b),   8'h0);
    chk("rst_alu_ctl",  8'(alu_control), 8'h0);
    chk("rst_imm_src",  8'(imm_src),     8'h0);

    // R-type SUB: 0,1,6,8,0
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    reset = 1'b0;
    #1;
    chk("fetch_state",   8'(state),       8'h0);
    chk("fetch_pcw",     8'(pc_write),    8'h1);
    chk("fetch_irw",     8'(ir_write),    8'h1);
    chk("fetch_b",       8'(alu_src_b),   8'h2);
    chk("fetch_res",     8'(result_src),  8'h2);
    chk("fetch_alu",     8'(alu_control), 8'h2);
    step();
    chk("r_dec_state",   8'(state),       8'h1);
    chk("r_dec_a",       8'(alu_src_a),   8'h1);
    chk("r_dec_b",       8'(alu_src_b),   8'h1);
    chk("r_dec_regw",    8'(reg_write),   8'h0);
    step();
    chk("r_exec_state",  8'(state),       8'h6);
    chk("r_exec_alu",    8'(alu_control), 8'h3);
    chk("r_exec_a",      8'(alu_src_a),   8'h2);
    chk("r_exec_regw",   8'(reg_write),   8'h0);
    step();
    chk("r_wb_state",    8'(state),       8'h8);
    chk("r_wb_regw",     8'(reg_write),   8'h1);
    chk("r_wb_res",      8'(result_src),  8'h0);
    step();
    chk("r_end_state",   8'(state),       8'h0);

    // Load: 0,1,2,3,4,0
    opcode = 7'b0000011;
    step();
    chk("ld_dec_state",  8'(state),       8'h1);
    step();
    chk("ld_adr_state",  8'(state),       8'h2);
    chk("ld_adr_a",      8'(alu_src_a),   8'h2);
    chk("ld_adr_b",      8'(alu_src_b),   8'h1);
    step();
    chk("ld_rd_state",   8'(state),       8'h3);
    chk("ld_rd_adr",     8'(adr_src),     8'h1);
    chk("ld_rd_memw",    8'(mem_write),   8'h0);
    step();
    chk("ld_wb_state",   8'(state),       8'h4);
    chk("ld_wb_res",     8'(result_src),  8'h1);
    chk("ld_wb_regw",    8'(reg_write),   8'h1);
    step();
    chk("ld_end_state",  8'(state),       8'h0);

    // I-type funct3=000 with funct7b5=1 stays ADD; then SRAI
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step();
    step();
    chk("addi_state",    8'(state),       8'h7);
    chk("addi_alu",      8'(alu_control), 8'h2);
    chk("addi_b",        8'(alu_src_b),   8'h1);
    funct3 = 3'b101;
    #1;
    chk("srai_alu",      8'(alu_control), 8'hA);
    funct7b5 = 1'b0;
    #1;
    chk("srli_alu",      8'(alu_control), 8'h9);
    step();
    chk("i_wb_state",    8'(state),       8'h8);
    step();
    chk("i_end_state",   8'(state),       8'h0);

    // Branch: 0,1,9,0 with condition sweep inside BRANCH
    opcode = 7'b1100011; funct3 = 3'b001; zero = 1'b0;
    step();
    chk("br_dec_imm",    8'(imm_src),     8'h2);
    step();
    chk("br_state",      8'(state),       8'h9);
    chk("bne_nz_pcw",    8'(pc_write),    8'h1);
    chk("bne_alu",       8'(alu_control), 8'h3);
    zero = 1'b1;
    #1;
    chk("bne_z_pcw",     8'(pc_write),    8'h0);
    chk("bne_z_alu",     8'(alu_control), 8'h3);
    funct3 = 3'b111;
    #1;
    chk("bgeu_z_pcw",    8'(pc_write),    8'h1);
    chk("bgeu_alu",      8'(alu_control), 8'h4);
    funct3 = 3'b100; zero = 1'b0;
    #1;
    chk("blt_nz_pcw",    8'(pc_write),    8'h1);
    chk("blt_alu",       8'(alu_control), 8'h5);
    funct3 = 3'b010; zero = 1'b1;
    #1;
    chk("br010_pcw",     8'(pc_write),    8'h0);
    zero = 1'b0;
    #1;
    chk("br010_nz_pcw",  8'(pc_write),    8'h0);
    step();
    chk("br_end_state",  8'(state),       8'h0);

    // JALR: 0,1,11,10,8,0
    opcode = 7'b1100111; funct3 = 3'b000;
    step();
    step();
    chk("jalr_state",    8'(state),       8'hB);
    chk("jalr_a",        8'(alu_src_a),   8'h2);
    chk("jalr_pcw",      8'(pc_write),    8'h0);
    step();
    chk("jal_state",     8'(state),       8'hA);
    chk("jal_pcw",       8'(pc_write),    8'h1);
    chk("jal_a",         8'(alu_src_a),   8'h1);
    chk("jal_b",         8'(alu_src_b),   8'h2);
    step();
    chk("jalr_wb_state", 8'(state),       8'h8);
    chk("jalr_wb_regw",  8'(reg_write),   8'h1);
    step();
    chk("jalr_end",      8'(state),       8'h0);

    // LUI: 0,1,12,8
    opcode = 7'b0110111;
    step();
    step();
    chk("lui_state",     8'(state),       8'hC);
    chk("lui_a",         8'(alu_src_a),   8'h3);
    chk("lui_imm",       8'(imm_src),     8'h4);
    step();
    chk("lui_wb_state",  8'(state),       8'h8);
    step();

    // Illegal opcode: DECODE straight back to FETCH
    opcode = 7'b1111111;
    step();
    chk("ill_dec_state", 8'(state),       8'h1);
    chk("ill_dec_memw",  8'(mem_write),   8'h0);
    step();
    chk("ill_state",     8'(state),       8'h0);
    chk("ill_regw",      8'(reg_write),   8'h0);
    chk("ill_memw",      8'(mem_write),   8'h0);

    // Store, then reset in MEMWRITE
    opcode = 7'b0100011;
    step();
    step();
    chk("st_adr_imm",    8'(imm_src),     8'h1);
    step();
    chk("st_wr_state",   8'(state),       8'h5);
    chk("st_wr_memw",    8'(mem_write),   8'h1);
    chk("st_wr_adr",     8'(adr_src),     8'h1);
    reset = 1'b1;
    #1;
    chk("st_rst_memw",   8'(mem_write),   8'h0);
    chk("st_rst_state",  8'(state),       8'h0);
    step();
    chk("st_rst2_memw",  8'(mem_write),   8'h0);
    chk("st_rst2_pcw",   8'(pc_write),    8'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_st",   8'(state),       8'h0);
    chk("post_rst_irw",  8'(ir_write),    8'h1);
    step();
    chk("post_rst_dec",  8'(state),       8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for RV32I.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-006 funct3  in  3  instruction bits [14:12].
REQ-007 funct7b5  in  1  instruction bit 30.
REQ-008 zero  in  1  ALU zero flag for the current cycle's result.
REQ-009 pc_write  out  1  PC register load enable.
REQ-010 adr_src  out  1  memory address select: 0 = PC, 1 = result.
REQ-011 mem_write  out  1  data memory write enable.
REQ-012 ir_write  out  1  instruction register and old_pc load enable.
REQ-013 result_src  out  2  result mux select: 00 = alu_out register, 01 = data register, 10 = ALU result.
REQ-014 alu_src_a  out  2  ALU A-input select: 00 = PC, 01 = old_pc, 10 = rs1 register, 11 = constant 0.
REQ-015 alu_src_b  out  2  ALU B-input select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
REQ-016 imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-017 reg_write  out  1  register file write enable.
REQ-018 alu_control  out  4  ALU operation code.
REQ-019 state  out  4  current FSM state, for debug.

Function
REQ-020 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0011, SLTU 0100, SLT 0101, XOR 0111, SLL 1000, SRL 1001, SRA 1010.
REQ-021 States SHALL be encoded as: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13.
REQ-022 The FSM SHALL be Moore: every output is a function of state, with opcode, funct3 and funct7b5 used only for ALU decode, branch decision and imm_src; any output not listed for a state is 0.
REQ-023 FETCH: adr_src=0, ir_write=1, A=00, B=10, ADD, result_src=10, pc_write=1; next state DECODE.
REQ-024 DECODE: A=01, B=01, ADD (old_pc+imm latched into alu_out); next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other opcode -> FETCH, with no write enables asserted.
REQ-025 MEMADR: A=10, B=01, ADD; next state MEMREAD if opcode is 0000011, else MEMWRITE.
REQ-026 MEMREAD: result_src=00, adr_src=1; next state MEMWB.
REQ-027 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-028 MEMWRITE: result_src=00, adr_src=1, mem_write=1; next state FETCH.
REQ-029 EXECR: A=10, B=00; EXECI: A=10, B=01; both use the funct3 ALU decode and go next to ALUWB.
REQ-030 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-031 funct3 ALU decode SHALL be:
  - 000: SUB if R-type and funct7b5=1, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5=1, else SRL
  - 110: OR
  - 111: AND
REQ-032 BRANCH: A=10, B=00, result_src=00; next state FETCH; alu_control and take condition by funct3:
  - 000 SUB, take if zero
  - 001 SUB, take if !zero
  - 100 SLT, take if !zero
  - 101 SLT, take if zero
  - 110 SLTU, take if !zero
  - 111 SLTU, take if zero
  - 010 and 011: never taken.
REQ-033 In BRANCH, pc_write SHALL equal the take condition.
REQ-034 JAL: A=01, B=10, ADD, result_src=00, pc_write=1 (PC <= target); next state ALUWB (rd <= old_pc+4).
REQ-035 JALR: A=10, B=01, ADD (target into alu_out); next state JAL.
REQ-036 LUI: A=11, B=01, ADD; AUIPC: A=01, B=01, ADD; both go next to ALUWB.
REQ-037 imm_src SHALL be decoded from opcode in every state:
  - 0100011 -> 001 (S)
  - 1100011 -> 010 (B)
  - 1101111 -> 011 (J)
  - 0110111 or 0010111 -> 100 (U)
  - otherwise -> 000 (I).
REQ-038 Cycles per instruction SHALL be: load 5, store 4, R/I/LUI/AUIPC 4, branch 3, JAL 4, JALR 5.

Reset
REQ-039 reset=1 at a rising edge SHALL force state to FETCH, including mid-instruction.
REQ-040 While reset=1, pc_write, mem_write, ir_write and reg_write SHALL be 0, and all other outputs SHALL be 0.
REQ-041 The first cycle after reset deasserts SHALL be FETCH with normal FETCH outputs.

Verification
REQ-042 Reset, then opcode=0110011, funct3=000, funct7b5=1 -> states 0,1,6,8,0; alu_control=0011 in EXECR; reg_write=1 only in ALUWB.
REQ-043 opcode=0000011 -> states 0,1,2,3,4; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB.
REQ-044 opcode=1100011, funct3=001 -> zero=0 in BRANCH gives pc_write=1; zero=1 gives pc_write=0; both with alu_control=0011.
REQ-045 opcode=1100111 -> states 0,1,11,10,8; pc_write=1 in JAL; reg_write=1 in ALUWB.
REQ-046 opcode=1111111 -> DECODE returns to FETCH with mem_write=0 and reg_write=0.
REQ-047 reset=1 asserted in MEMWRITE -> state=0 next cycle and mem_write=0 during reset.
